// File: rtl/roic_pkg.sv
// Shared defaults, FSM state encodings and pixel addressing for the ROIC frame
// capture block.
package roic_pkg;

    localparam int unsigned ROIC_ROWS = 3;
    localparam int unsigned ROIC_COLS = 3;
    localparam int unsigned ROIC_AW   = 3;
    localparam int unsigned ROIC_DW   = 12;
    localparam int unsigned ROIC_CW   = 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_INTG,
        W_READ
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rstate_e;

    function automatic int unsigned pix_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/roic_frame_capture_if.sv
// Raster-order pixel stream with valid/ready handshake toward the host/packetiser.
interface roic_frame_capture_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 12
) ();

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_row;
    logic [AW-1:0] out_col;
    logic          out_sof;
    logic          out_eof;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_row,
        output out_col,
        output out_sof,
        output out_eof
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_sof,
        input  out_eof
    );

endinterface

// File: rtl/roic_pingpong_ram.sv
// Two-bank frame store: one write port and one registered read port, each with
// its own bank select.
module roic_pingpong_ram #(
    parameter int unsigned DEPTH = 9,
    parameter int unsigned DW    = 12,
    parameter int unsigned IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [IW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_bank_i,
    input  logic [IW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] bank0_q [DEPTH];
    logic [DW-1:0] bank1_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (wr_bank_i) begin
                bank1_q[wr_addr_i] <= wr_data_i;
            end else begin
                bank0_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_bank_i ? bank1_q[rd_addr_i] : bank0_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/roic_frame_capture.sv
// Assembles scanner-timed ADC samples into ROWS x COLS frames in a ping-pong
// buffer and streams completed frames out in raster order.
module roic_frame_capture
    import roic_pkg::*;
#(
    parameter int unsigned ROWS = ROIC_ROWS,
    parameter int unsigned COLS = ROIC_COLS,
    parameter int unsigned AW   = ROIC_AW,
    parameter int unsigned DW   = ROIC_DW,
    parameter int unsigned CW   = ROIC_CW
) (
    input  logic                   clk,
    input  logic                   master_rst,
    input  logic                   fsync,
    input  logic                   intg,
    input  logic [AW-1:0]          row,
    input  logic [AW-1:0]          col,
    input  logic                   adc_valid,
    input  logic [DW-1:0]          adc_data,
    roic_frame_capture_if.master   out,
    output logic [CW-1:0]          drop_cnt,
    output logic                   frame_err
);

    localparam int unsigned NPIX = ROWS * COLS;
    localparam int unsigned IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    // Write side state
    wstate_e         w_state_q;
    logic [NPIX-1:0] mask_q;
    logic [NPIX-1:0] mask_d;
    logic            w_sel_q;
    logic            skip_q;
    logic [1:0]      full_q;
    logic [CW-1:0]   drop_q;
    logic            err_q;

    logic            in_range;
    logic [IW-1:0]   wr_idx;
    logic            sample;
    logic            accept;
    logic            abort;
    logic            wr_block;
    logic            complete;
    logic            commit;
    logic            drop;

    // Read side state
    rstate_e         r_state_q;
    logic            r_sel_q;
    logic            valid_q;
    logic [IW-1:0]   ptr_q;
    logic [AW-1:0]   orow_q;
    logic [AW-1:0]   ocol_q;
    logic            sof_q;
    logic            eof_q;

    logic            hs;
    logic            start;
    logic            adv;
    logic            rd_release;
    logic [IW-1:0]   nidx;
    logic [AW-1:0]   nrow;
    logic [AW-1:0]   ncol;
    logic            neof;
    logic            rd_bank;
    logic [DW-1:0]   rd_data;

    always_comb begin
        in_range = (32'(row) < ROWS) && (32'(col) < COLS);
        wr_idx   = IW'(pix_idx(32'(row), 32'(col), COLS));
        sample   = (w_state_q == W_READ) && adc_valid && !fsync;
        accept   = sample && in_range;
        abort    = fsync && (w_state_q != W_IDLE);
        wr_block = full_q[w_sel_q];
        mask_d   = mask_q;
        if (accept) begin
            mask_d[wr_idx] = 1'b1;
        end
        complete = accept && (&mask_d);
        // A frame commits only if its target bank stayed free for the whole
        // capture; otherwise the samples never reached the RAM and it is dropped.
        commit   = complete && !skip_q && !wr_block;
        drop     = (complete && !commit) || abort;
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            w_state_q <= W_IDLE;
            mask_q    <= '0;
            w_sel_q   <= 1'b0;
            skip_q    <= 1'b0;
            full_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (rd_release) begin
                full_q[r_sel_q] <= 1'b0;
            end
            if (commit) begin
                full_q[w_sel_q] <= 1'b1;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CW'(1);
            end
            if (abort || (sample && !in_range)) begin
                err_q <= 1'b1;
            end
            case (w_state_q)
                W_IDLE: begin
                    if (fsync) begin
                        w_state_q <= W_INTG;
                        mask_q    <= '0;
                        skip_q    <= 1'b0;
                    end
                end
                W_INTG: begin
                    if (fsync) begin
                        mask_q <= '0;
                        skip_q <= 1'b0;
                    end else if (!intg) begin
                        w_state_q <= W_READ;
                    end
                end
                W_READ: begin
                    if (fsync) begin
                        w_state_q <= W_INTG;
                        mask_q    <= '0;
                        skip_q    <= 1'b0;
                    end else if (accept) begin
                        mask_q <= mask_d;
                        skip_q <= skip_q | wr_block;
                        if (complete) begin
                            w_state_q <= W_IDLE;
                            if (commit) begin
                                w_sel_q <= ~w_sel_q;
                            end
                        end
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        hs         = valid_q && out.out_ready;
        start      = (r_state_q == R_IDLE) && full_q[~w_sel_q];
        rd_release = (r_state_q == R_STREAM) && hs && eof_q;
        adv        = (r_state_q == R_STREAM) && hs && !eof_q;
        nidx       = ptr_q;
        nrow       = orow_q;
        ncol       = ocol_q;
        if (start) begin
            nidx = '0;
            nrow = '0;
            ncol = '0;
        end else if (adv) begin
            nidx = ptr_q + IW'(1);
            if (ocol_q == AW'(COLS - 1)) begin
                ncol = '0;
                nrow = orow_q + AW'(1);
            end else begin
                ncol = ocol_q + AW'(1);
            end
        end
        neof    = (nrow == AW'(ROWS - 1)) && (ncol == AW'(COLS - 1));
        rd_bank = start ? ~w_sel_q : r_sel_q;
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            r_state_q <= R_IDLE;
            r_sel_q   <= 1'b0;
            valid_q   <= 1'b0;
            ptr_q     <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (start) begin
                        r_state_q <= R_STREAM;
                        r_sel_q   <= ~w_sel_q;
                        valid_q   <= 1'b1;
                        ptr_q     <= nidx;
                        orow_q    <= nrow;
                        ocol_q    <= ncol;
                        sof_q     <= 1'b1;
                        eof_q     <= neof;
                    end
                end
                R_STREAM: begin
                    if (rd_release) begin
                        r_state_q <= R_IDLE;
                        valid_q   <= 1'b0;
                        sof_q     <= 1'b0;
                        eof_q     <= 1'b0;
                    end else if (adv) begin
                        ptr_q  <= nidx;
                        orow_q <= nrow;
                        ocol_q <= ncol;
                        sof_q  <= 1'b0;
                        eof_q  <= neof;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    roic_pingpong_ram #(
        .DEPTH (NPIX),
        .DW    (DW),
        .IW    (IW)
    ) u_ram (
        .clk       (clk),
        .rst       (master_rst),
        .we_i      (accept && !wr_block),
        .wr_bank_i (w_sel_q),
        .wr_addr_i (wr_idx),
        .wr_data_i (adc_data),
        .rd_en_i   (start || adv),
        .rd_bank_i (rd_bank),
        .rd_addr_i (nidx),
        .rd_data_o (rd_data)
    );

    assign out.out_valid = valid_q;
    assign out.out_data  = rd_data;
    assign out.out_row   = orow_q;
    assign out.out_col   = ocol_q;
    assign out.out_sof   = sof_q;
    assign out.out_eof   = eof_q;
    assign drop_cnt      = drop_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_roic_frame_capture.sv
// Directed scenario bench for roic_frame_capture on a 3x3, 12-bit configuration.
module tb_roic_frame_capture;

    logic        clk = 1'b0;
    logic        master_rst = 1'b1;
    logic        fsync = 1'b0;
    logic        intg = 1'b0;
    logic [2:0]  row = '0;
    logic [2:0]  col = '0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic [7:0]  drop_cnt;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    logic [11:0] cap_data [32];
    logic [2:0]  cap_row  [32];
    logic [2:0]  cap_col  [32];
    logic        cap_sof  [32];
    logic        cap_eof  [32];
    int          cap_n;
    int          stall_bad;

    always #5 clk = ~clk;

    roic_frame_capture_if #(.AW(3), .DW(12)) out_if ();

    roic_frame_capture #(
        .ROWS (3),
        .COLS (3),
        .AW   (3),
        .DW   (12),
        .CW   (8)
    ) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .fsync      (fsync),
        .intg       (intg),
        .row        (row),
        .col        (col),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .out        (out_if),
        .drop_cnt   (drop_cnt),
        .frame_err  (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pixel(input logic [2:0] r, input logic [2:0] c, input logic [11:0] d);
        row = r;
        col = c;
        adc_data = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic start_frame();
        fsync = 1'b1;
        intg = 1'b1;
        tick();
        fsync = 1'b0;
        repeat (5) tick();
        intg = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [11:0] base, input int npix, input bit oor);
        start_frame();
        for (int i = 0; i < npix; i++) begin
            if (oor && i == 3) put_pixel(3'd3, 3'd1, 12'hBAD);
            if (oor && i == 4) put_pixel(3'd0, 3'd3, 12'hBAD);
            put_pixel(3'(i / 3), 3'(i % 3), base + 12'(i));
        end
    endtask

    // Gathers accepted beats; counts any stalled beat that changed or vanished.
    task automatic collect(input int n, input int budget, input bit toggle);
        logic        prev_stall = 1'b0;
        logic [11:0] p_data = '0;
        logic [2:0]  p_row = '0;
        logic [2:0]  p_col = '0;
        logic        p_sof = 1'b0;
        logic        p_eof = 1'b0;
        cap_n = 0;
        stall_bad = 0;
        for (int cyc = 0; cyc < budget && cap_n < n; cyc++) begin
            out_if.out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (prev_stall && (!out_if.out_valid || out_if.out_data !== p_data ||
                               out_if.out_row !== p_row || out_if.out_col !== p_col ||
                               out_if.out_sof !== p_sof || out_if.out_eof !== p_eof))
                stall_bad++;
            if (out_if.out_valid && out_if.out_ready) begin
                cap_data[cap_n] = out_if.out_data;
                cap_row[cap_n]  = out_if.out_row;
                cap_col[cap_n]  = out_if.out_col;
                cap_sof[cap_n]  = out_if.out_sof;
                cap_eof[cap_n]  = out_if.out_eof;
                cap_n++;
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            p_data = out_if.out_data;
            p_row  = out_if.out_row;
            p_col  = out_if.out_col;
            p_sof  = out_if.out_sof;
            p_eof  = out_if.out_eof;
            tick();
        end
        out_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        master_rst = 1'b1;
        out_if.out_ready = 1'b0;
        repeat (3) tick();
        master_rst = 1'b0;
        checks++;
        if ({out_if.out_valid, out_if.out_sof, out_if.out_eof, out_if.out_data,
             out_if.out_row, out_if.out_col} !== 20'h0) begin
            errors++;
            $display("FAIL reset_out: got v=%b sof=%b eof=%b d=%h r=%0d c=%0d want all 0",
                     out_if.out_valid, out_if.out_sof, out_if.out_eof, out_if.out_data,
                     out_if.out_row, out_if.out_col);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", frame_err);
        end
    endtask

    task automatic test_nominal();
        out_if.out_ready = 1'b1;
        send_frame(12'h100, 9, 1'b0);
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nom_latency0: got valid=%b want 0", out_if.out_valid);
        end
        tick();
        checks++;
        if (out_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL nom_latency1: got valid=%b want 1", out_if.out_valid);
        end
        collect(9, 40, 1'b0);
        checks++;
        if (cap_n !== 9) begin
            errors++;
            $display("FAIL nom_count: got %0d beats want 9", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_data[i] !== 12'h100 + 12'(i)) begin
                errors++;
                $display("FAIL nom_data[%0d]: got %h want %h", i, cap_data[i], 12'h100 + 12'(i));
            end
            checks++;
            if ({cap_row[i], cap_col[i]} !== {3'(i / 3), 3'(i % 3)}) begin
                errors++;
                $display("FAIL nom_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                         cap_row[i], cap_col[i], i / 3, i % 3);
            end
            checks++;
            if ({cap_sof[i], cap_eof[i]} !== {i == 0, i == 8}) begin
                errors++;
                $display("FAIL nom_flags[%0d]: got sof=%b eof=%b want sof=%b eof=%b", i,
                         cap_sof[i], cap_eof[i], i == 0, i == 8);
            end
        end
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nom_gap: got valid=%b after eof want 0", out_if.out_valid);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL nom_drop: got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_if.out_ready = 1'b0;
        send_frame(12'h200, 9, 1'b0);
        collect(9, 80, 1'b1);
        checks++;
        if (cap_n !== 9) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 9", cap_n);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stalled cycles want 0", stall_bad);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if ({cap_data[i], cap_row[i], cap_col[i]} !== {12'h200 + 12'(i), 3'(i / 3), 3'(i % 3)}) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got %h@(%0d,%0d) want %h@(%0d,%0d)", i,
                         cap_data[i], cap_row[i], cap_col[i], 12'h200 + 12'(i), i / 3, i % 3);
            end
        end
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap: got valid=%b want 0", out_if.out_valid);
        end
    endtask

    task automatic test_overrun();
        out_if.out_ready = 1'b0;
        send_frame(12'h300, 9, 1'b0);
        send_frame(12'h400, 9, 1'b0);
        send_frame(12'h500, 9, 1'b0);
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovr_drop: got %0d want 1", drop_cnt);
        end
        checks++;
        if ({out_if.out_valid, out_if.out_sof, out_if.out_data} !== {1'b1, 1'b1, 12'h300}) begin
            errors++;
            $display("FAIL ovr_hold: got v=%b sof=%b d=%h want v=1 sof=1 d=300",
                     out_if.out_valid, out_if.out_sof, out_if.out_data);
        end
        collect(18, 100, 1'b0);
        checks++;
        if (cap_n !== 18) begin
            errors++;
            $display("FAIL ovr_count: got %0d beats want 18", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            logic [11:0] exp_d;
            exp_d = (i < 9) ? 12'h300 + 12'(i) : 12'h400 + 12'(i - 9);
            checks++;
            if (cap_data[i] !== exp_d) begin
                errors++;
                $display("FAIL ovr_data[%0d]: got %h want %h", i, cap_data[i], exp_d);
            end
        end
        repeat (10) tick();
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_no_c: got valid=%b data=%h want no further frame",
                     out_if.out_valid, out_if.out_data);
        end
    endtask

    task automatic test_abort();
        out_if.out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 4; i++) put_pixel(3'(i / 3), 3'(i % 3), 12'hA00 + 12'(i));
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial: got valid=%b want 0", out_if.out_valid);
        end
        send_frame(12'h600, 9, 1'b0);
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL abort_drop: got %0d want 2", drop_cnt);
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_err: got %b want 1", frame_err);
        end
        collect(9, 40, 1'b0);
        checks++;
        if (cap_n !== 9) begin
            errors++;
            $display("FAIL abort_count: got %0d beats want 9", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if ({cap_data[i], cap_sof[i]} !== {12'h600 + 12'(i), i == 0}) begin
                errors++;
                $display("FAIL abort_beat[%0d]: got %h sof=%b want %h sof=%b", i,
                         cap_data[i], cap_sof[i], 12'h600 + 12'(i), i == 0);
            end
        end
    endtask

    task automatic test_midreset();
        bit found = 1'b0;
        out_if.out_ready = 1'b1;
        send_frame(12'h800, 9, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_if.out_valid && out_if.out_data === 12'h804) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found || {out_if.out_row, out_if.out_col} !== {3'd1, 3'd1}) begin
            errors++;
            $display("FAIL mr_beat4: got found=%b at (%0d,%0d) want beat 4 at (1,1)",
                     found, out_if.out_row, out_if.out_col);
        end
        master_rst = 1'b1;
        tick();
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_valid: got %b want 0", out_if.out_valid);
        end
        master_rst = 1'b0;
        checks++;
        if ({drop_cnt, frame_err} !== 9'd0) begin
            errors++;
            $display("FAIL mr_status: got drop=%0d err=%b want 0/0", drop_cnt, frame_err);
        end
        repeat (5) tick();
        checks++;
        if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_discard: got valid=%b want 0", out_if.out_valid);
        end
        send_frame(12'h900, 9, 1'b0);
        collect(9, 40, 1'b0);
        checks++;
        if (cap_n !== 9) begin
            errors++;
            $display("FAIL mr_count: got %0d beats want 9", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if ({cap_data[i], cap_row[i], cap_col[i], cap_sof[i]} !==
                {12'h900 + 12'(i), 3'(i / 3), 3'(i % 3), i == 0}) begin
                errors++;
                $display("FAIL mr_beat[%0d]: got %h@(%0d,%0d) sof=%b want %h@(%0d,%0d) sof=%b",
                         i, cap_data[i], cap_row[i], cap_col[i], cap_sof[i],
                         12'h900 + 12'(i), i / 3, i % 3, i == 0);
            end
        end
    endtask

    task automatic test_out_of_range();
        master_rst = 1'b1;
        tick();
        master_rst = 1'b0;
        out_if.out_ready = 1'b1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_pre_err: got %b want 0", frame_err);
        end
        send_frame(12'h700, 9, 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err: got %b want 1", frame_err);
        end
        collect(9, 40, 1'b0);
        checks++;
        if (cap_n !== 9) begin
            errors++;
            $display("FAIL oor_count: got %0d beats want 9", cap_n);
        end
        for (int i = 0; i < cap_n; i++) begin
            checks++;
            if (cap_data[i] !== 12'h700 + 12'(i)) begin
                errors++;
                $display("FAIL oor_data[%0d]: got %h want %h", i, cap_data[i], 12'h700 + 12'(i));
            end
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL oor_drop: got %0d want 0", drop_cnt);
        end
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_overrun();
        test_abort();
        test_midreset();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1);
    end

endmodule
